// File: rtl/write_buffer.sv
// write_buffer: store queue between a write-through data cache and data memory.
//
// Stores (word or byte) are queued in a DEPTH-entry FIFO and drained to memory
// one req/ack transaction at a time, so the core does not wait for memory on a
// store. Read-miss fetches go to memory ahead of queued stores. A read whose
// youngest matching queued store is a full word is answered from the queue
// without touching memory. A read whose youngest match is a byte store waits
// until every matching entry has drained.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   cpu_write_enable_i     store request (wins if both enables are high)
//   cpu_read_enable_i      read-miss fetch request
//   cpu_byte_op_i          store is a single byte, lane = address[1:0]
//   cpu_address_i          request byte address
//   cpu_write_data_i       store data (byte stores use [7:0])
//   cpu_read_data_o        read data, valid in the cycle the read completes
//   stall_o                request not completed this cycle
//   mem_req_o/mem_we_o     registered memory request / write-not-read
//   mem_byte_op_o          registered byte-write flag
//   mem_address_o          registered transaction address
//   mem_write_data_o       registered write data
//   mem_ack_i              memory completes the current transaction
//   mem_read_data_i        read data, valid with mem_ack_i
module write_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cpu_write_enable_i,
  input  logic             cpu_read_enable_i,
  input  logic             cpu_byte_op_i,
  input  logic [WIDTH-1:0] cpu_address_i,
  input  logic [WIDTH-1:0] cpu_write_data_i,
  output logic [WIDTH-1:0] cpu_read_data_o,
  output logic             stall_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             mem_byte_op_o,
  output logic [WIDTH-1:0] mem_address_o,
  output logic [WIDTH-1:0] mem_write_data_o,
  input  logic             mem_ack_i,
  input  logic [WIDTH-1:0] mem_read_data_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ
  } state_t;

  state_t state;

  logic [WIDTH-1:0] addr_mem [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic             byte_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic             full;
  logic             push;
  logic             pop;
  logic             read_req;
  logic             fwd_hit;
  logic             hazard;
  logic             read_pending;
  logic [WIDTH-1:0] fwd_data;

  assign full     = (count == CNT_W'(DEPTH));
  // A full queue refuses the store even when the head pops this cycle.
  assign push     = cpu_write_enable_i && !full;
  assign pop      = (state == WRITE) && mem_ack_i;
  assign read_req = cpu_read_enable_i && !cpu_write_enable_i;

  // Walk the live entries oldest to youngest; the last match seen is the
  // youngest, which is the one a load must observe.
  always_comb begin : forward_search
    logic [PTR_W-1:0] idx;
    logic             match_found;
    logic             match_byte;
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    idx         = '0;
    match_found = 1'b0;
    match_byte  = 1'b0;
    fwd_data    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) &&
          (addr_mem[idx][WIDTH-1:2] == cpu_address_i[WIDTH-1:2])) begin
        match_found = 1'b1;
        match_byte  = byte_mem[idx];
        fwd_data    = data_mem[idx];
      end
    end
    fwd_hit = read_req && match_found && !match_byte;
    hazard  = read_req && match_found && match_byte;
  end

  assign read_pending = read_req && !fwd_hit && !hazard;

  always_comb begin
    stall_o         = 1'b0;
    cpu_read_data_o = '0;
    if (cpu_write_enable_i) begin
      stall_o = full;
    end else if (cpu_read_enable_i) begin
      if (fwd_hit) begin
        cpu_read_data_o = fwd_data;
      end else if (!hazard && (state == READ) && mem_ack_i) begin
        cpu_read_data_o = mem_read_data_i;
      end else begin
        stall_o = 1'b1;
      end
    end
  end

  // NOTE: the entry storage has no reset; count and the pointers alone decide
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr] <= cpu_address_i;
      data_mem[wr_ptr] <= cpu_write_data_i;
      byte_mem[wr_ptr] <= cpu_byte_op_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Memory-side sequencer. Outputs are registered and held until ack; a
  // pending read is launched ahead of any queued store.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= IDLE;
      mem_req_o        <= 1'b0;
      mem_we_o         <= 1'b0;
      mem_byte_op_o    <= 1'b0;
      mem_address_o    <= '0;
      mem_write_data_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read_pending) begin
            state            <= READ;
            mem_req_o        <= 1'b1;
            mem_we_o         <= 1'b0;
            mem_byte_op_o    <= 1'b0;
            mem_address_o    <= {cpu_address_i[WIDTH-1:2], 2'b00};
            mem_write_data_o <= '0;
          end else if (count != '0) begin
            state            <= WRITE;
            mem_req_o        <= 1'b1;
            mem_we_o         <= 1'b1;
            mem_byte_op_o    <= byte_mem[rd_ptr];
            mem_address_o    <= addr_mem[rd_ptr];
            mem_write_data_o <= data_mem[rd_ptr];
          end
        end
        WRITE, READ: begin
          if (mem_ack_i) begin
            state            <= IDLE;
            mem_req_o        <= 1'b0;
            mem_we_o         <= 1'b0;
            mem_byte_op_o    <= 1'b0;
            mem_address_o    <= '0;
            mem_write_data_o <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
